onion_timer_core: RTL and testbench

//   Period timer core driven by the TIMER_x_CONFIG register fields (period[30:0], enable[31]).

---
 rtl/onion_timer_core.sv | 136 +++++++++++++
 tb/tb_onion_timer_core.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/onion_timer_core.sv
// Period timer core: synchronised enable, IDLE/LOAD/RUN FSM, square wave, expiry tick and counter.
// Optional one-shot mode (oneshot_i port, DONE state) is built when ONION_TIMER_CORE_ONESHOT_EN is defined.
module onion_timer_core #(
  parameter int PERIOD_WIDTH   = 31,
  parameter int TICK_CNT_WIDTH = 16,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      TIMER_clk,
  input  logic                      TIMER_rst_n,
  input  logic [PERIOD_WIDTH-1:0]   period_i,
  input  logic                      enable_i,
`ifdef ONION_TIMER_CORE_ONESHOT_EN
  input  logic                      oneshot_i,
`endif
  output logic                      TIMER_o,
  output logic                      TIMER_dbg_o,
  output logic [TICK_CNT_WIDTH-1:0] tick_cnt_o,
  output logic                      running_o
);

`ifdef ONION_TIMER_CORE_ONESHOT_EN
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_DONE} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} state_e;
`endif

  state_e                    state_q, state_d;
  logic [SYNC_STAGES-1:0]    sync_q, sync_d;
  logic [PERIOD_WIDTH-1:0]   cnt_q, cnt_d;
  logic [PERIOD_WIDTH-1:0]   period_q, period_d;
  logic                      timer_q, timer_d;
  logic                      dbg_q, dbg_d;
  logic [TICK_CNT_WIDTH-1:0] tick_q, tick_d;
  logic                      en_s;
`ifdef ONION_TIMER_CORE_ONESHOT_EN
  logic                      oneshot_q, oneshot_d;
`endif

  // enable_i crosses from the bus clock; only the last synchroniser stage is observed.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], enable_i};
  assign en_s   = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    timer_d  = timer_q;
    dbg_d    = 1'b0;
    tick_d   = tick_q;
`ifdef ONION_TIMER_CORE_ONESHOT_EN
    oneshot_d = oneshot_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (en_s) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        period_d = (period_i == '0) ? PERIOD_WIDTH'(1) : period_i;
        cnt_d    = period_d - PERIOD_WIDTH'(1);
        tick_d   = '0;
        timer_d  = 1'b0;
`ifdef ONION_TIMER_CORE_ONESHOT_EN
        oneshot_d = oneshot_i;
`endif
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        // A disable wins over a coincident expiry: no toggle, tick or count.
        if (!en_s) begin
          state_d = ST_IDLE;
          timer_d = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          cnt_d   = period_q - PERIOD_WIDTH'(1);
          timer_d = ~timer_q;
          dbg_d   = 1'b1;
          tick_d  = tick_q + TICK_CNT_WIDTH'(1);
`ifdef ONION_TIMER_CORE_ONESHOT_EN
          if (oneshot_q) begin
            timer_d = 1'b1;
            cnt_d   = '0;
            state_d = ST_DONE;
          end
`endif
        end else begin
          cnt_d = cnt_q - PERIOD_WIDTH'(1);
        end
      end
`ifdef ONION_TIMER_CORE_ONESHOT_EN
      ST_DONE: begin
        if (!en_s) begin
          state_d = ST_IDLE;
          timer_d = 1'b0;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        timer_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge TIMER_clk or negedge TIMER_rst_n) begin
    if (!TIMER_rst_n) begin
      state_q  <= ST_IDLE;
      sync_q   <= '0;
      cnt_q    <= '0;
      period_q <= '0;
      timer_q  <= 1'b0;
      dbg_q    <= 1'b0;
      tick_q   <= '0;
`ifdef ONION_TIMER_CORE_ONESHOT_EN
      oneshot_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      timer_q  <= timer_d;
      dbg_q    <= dbg_d;
      tick_q   <= tick_d;
`ifdef ONION_TIMER_CORE_ONESHOT_EN
      oneshot_q <= oneshot_d;
`endif
    end
  end

  assign TIMER_o     = timer_q;
  assign TIMER_dbg_o = dbg_q;
  assign tick_cnt_o  = tick_q;
  assign running_o   = (state_q == ST_RUN);

endmodule

// File: tb/tb_onion_timer_core.sv
// Bench for onion_timer_core: directed runs, expected expiry pulses queued and checked by a monitor.
module tb_onion_timer_core;
  localparam int PW = 31;
  localparam int TW = 4;
  localparam int EW = 32 + 1 + TW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable_i;
  logic [PW-1:0] period_i;
  logic          timer_o;
  logic          dbg_o;
  logic [TW-1:0] tick_cnt_o;
  logic          running_o;
`ifdef ONION_TIMER_CORE_ONESHOT_EN
  logic          oneshot_i;
`endif

  onion_timer_core #(.PERIOD_WIDTH(PW), .TICK_CNT_WIDTH(TW), .SYNC_STAGES(2)) dut (
    .TIMER_clk   (clk),
    .TIMER_rst_n (rst_n),
    .period_i    (period_i),
    .enable_i    (enable_i),
`ifdef ONION_TIMER_CORE_ONESHOT_EN
    .oneshot_i   (oneshot_i),
`endif
    .TIMER_o     (timer_o),
    .TIMER_dbg_o (dbg_o),
    .tick_cnt_o  (tick_cnt_o),
    .running_o   (running_o)
  );

  // Clock and edge counter; edge k of a run is cyc == base + k.
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int base = 0;
  // Entry: {absolute edge, TIMER_o after the edge, tick_cnt_o after the edge}
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every expiry pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && dbg_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dbg_unexpected: pulse at edge %0d with nothing expected", cyc);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("dbg_edge", cyc, e[EW-1:TW+1]);
        check("dbg_timer_o", {31'b0, timer_o}, {31'b0, e[TW]});
        check("dbg_tick_cnt", {{(32-TW){1'b0}}, tick_cnt_o}, {{(32-TW){1'b0}}, e[TW-1:0]});
      end
    end
  end

  task automatic wait_edge(input int k);
    while (cyc < base + k) @(negedge clk);
  endtask

  task automatic expect_pulse(input int edge_k, input int k);
    logic [31:0]   c;
    logic [TW-1:0] t;
    c = 32'(base + edge_k);
    t = TW'(k);
    exp_q.push_back({c, k[0], t});
  endtask

  // Expiries at edge 4+P*k; the last that survives a drop at edge drop_e is at drop_e+2.
  task automatic push_expiries(input int p, input int drop_e, output int last_k);
    int pe;
    pe = (p == 0) ? 1 : p;
    last_k = 0;
    for (int k = 1; 4 + pe * k <= drop_e + 2; k++) begin
      expect_pulse(4 + pe * k, k);
      last_k = k;
    end
  endtask

  task automatic run_case(input string tag, input int p, input int alt_p, input int drop_e);
    int last_k;
    @(negedge clk);
    period_i = PW'(p);
    enable_i = 1'b1;
    base = cyc;
    push_expiries(p, drop_e, last_k);
    wait_edge(3);
    check({tag, "_running_load"}, {31'b0, running_o}, 0);
    wait_edge(4);
    check({tag, "_running_run"}, {31'b0, running_o}, 1);
    check({tag, "_timer_start"}, {31'b0, timer_o}, 0);
    check({tag, "_tick_start"}, {{(32-TW){1'b0}}, tick_cnt_o}, 0);
    wait_edge(6);
    period_i = PW'(alt_p);
    wait_edge(drop_e);
    enable_i = 1'b0;
    wait_edge(drop_e + 2);
    check({tag, "_running_before_idle"}, {31'b0, running_o}, 1);
    wait_edge(drop_e + 3);
    check({tag, "_running_idle"}, {31'b0, running_o}, 0);
    check({tag, "_timer_idle"}, {31'b0, timer_o}, 0);
    check({tag, "_dbg_idle"}, {31'b0, dbg_o}, 0);
    check({tag, "_tick_hold"}, {{(32-TW){1'b0}}, tick_cnt_o}, last_k % (1 << TW));
    check({tag, "_pulses_left"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    enable_i = 1'b0;
    period_i = '0;
`ifdef ONION_TIMER_CORE_ONESHOT_EN
    oneshot_i = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_timer_o", {31'b0, timer_o}, 0);
    check("rst_dbg_o", {31'b0, dbg_o}, 0);
    check("rst_tick_cnt", {{(32-TW){1'b0}}, tick_cnt_o}, 0);
    check("rst_running", {31'b0, running_o}, 0);

    // Released with enable low: nothing moves.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_outputs", {28'b0, timer_o, dbg_o, running_o, |tick_cnt_o}, 0);
    end

    run_case("p5", 5, 5, 19);
    run_case("p0", 0, 0, 14);
    run_case("p4_change", 4, 10, 40);
    run_case("p10_restart", 10, 10, 50);
    run_case("p1_wrap", 1, 1, 20);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    period_i = PW'(3);
    enable_i = 1'b1;
    base = cyc;
    expect_pulse(7, 1);
    wait_edge(8);
    check("pre_rst_running", {31'b0, running_o}, 1);
    check("pre_rst_timer", {31'b0, timer_o}, 1);
    check("pre_rst_tick", {{(32-TW){1'b0}}, tick_cnt_o}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs", {28'b0, timer_o, dbg_o, running_o, |tick_cnt_o}, 0);
    check("async_rst_pulses_left", exp_q.size(), 0);
    @(negedge clk);
    enable_i = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_outputs", {28'b0, timer_o, dbg_o, running_o, |tick_cnt_o}, 0);

`ifdef ONION_TIMER_CORE_ONESHOT_EN
    @(negedge clk);
    oneshot_i = 1'b1;
    period_i = PW'(3);
    enable_i = 1'b1;
    base = cyc;
    expect_pulse(7, 1);
    wait_edge(7);
    check("os_timer_set", {31'b0, timer_o}, 1);
    check("os_running_done", {31'b0, running_o}, 0);
    check("os_tick", {{(32-TW){1'b0}}, tick_cnt_o}, 1);
    wait_edge(12);
    check("os_timer_held", {31'b0, timer_o}, 1);
    check("os_dbg_quiet", {31'b0, dbg_o}, 0);
    check("os_tick_held", {{(32-TW){1'b0}}, tick_cnt_o}, 1);
    enable_i = 1'b0;
    wait_edge(14);
    check("os_timer_before_idle", {31'b0, timer_o}, 1);
    wait_edge(15);
    check("os_timer_cleared", {31'b0, timer_o}, 0);
    check("os_pulses_left", exp_q.size(), 0);
    oneshot_i = 1'b0;
`endif

    repeat (3) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
